ysyx_23060286_ifu: RTL and testbench
====================================

YSYX_23060286_IFU -- requirements
Module: ysyx_23060286_ifu

Interface
REQ-001 Parameter: RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_req_valid  output  1  fetch request valid.
REQ-005 mem_req_ready  input  1  memory accepts request.
REQ-006 mem_req_addr  output  32  fetch address, word-aligned.
REQ-007 mem_resp_valid  input  1  read data valid, one cycle per accepted request.
REQ-008 mem_resp_data  input  32  fetched instruction word.
REQ-009 out_valid  output  1  instruction available to decode/immediate stage.
REQ-010 out_ready  input  1  decode stage accepts instruction.
REQ-011 out_inst  output  32  instruction word; bits [31:7] feed the immediate generator.
REQ-012 out_pc  output  32  address of out_inst.
REQ-013 redirect_valid  input  1  branch/jump redirect from execute.
REQ-014 redirect_pc  input  32  redirect target.
REQ-015 misalign_fault  output  1  redirect target not word-aligned.

Function
REQ-016 States IDLE, REQ, WAIT, OUT, FAULT; one outstanding request maximum.
REQ-017 IDLE: single cycle after reset release -> REQ.
REQ-018 REQ: mem_req_valid=1, mem_req_addr=pc; handshake (valid&ready) -> WAIT.
REQ-019 WAIT: on mem_resp_valid register data into out_inst, pc into out_pc -> OUT; out_valid rises the cycle after mem_resp_valid.
REQ-020 OUT: out_valid=1, out_inst/out_pc held stable until out_ready; on handshake pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0) -> REQ.
REQ-021 Minimum fetch-to-fetch: request accepted cycle N, response N+1, out_valid N+2, next request N+3 if out_ready at N+2.
REQ-022 Redirect (any state except FAULT) has priority over every handshake in the same cycle; pc<=redirect_pc next cycle.
REQ-023 Redirect in REQ without req handshake: stay REQ, new address presented next cycle.
REQ-024 Redirect in REQ with req handshake, or in WAIT: set drop flag, go/stay WAIT, discard the pending response (no out_valid), then REQ with new pc.
REQ-025 Redirect coincident with mem_resp_valid in WAIT: response discarded -> REQ.
REQ-026 Redirect in OUT: out_valid drops next cycle, held instruction discarded even if out_ready was high -> REQ.
REQ-027 mem_resp_valid outside WAIT is ignored.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, pc=RESET_PC, drop flag 0, mem_req_valid 0, mem_req_addr RESET_PC, out_valid 0, out_inst 0, out_pc 0, misalign_fault 0.
REQ-029 Reset mid-transaction abandons outstanding request; a response arriving after reset release is ignored (state not WAIT).

Configuration
REQ-030 Macro YSYX_23060286_IFU_MISALIGN_EN defined: redirect with redirect_pc[1:0]!=0 -> FAULT next cycle, misalign_fault=1, mem_req_valid=0, out_valid=0; FAULT exits only on reset or an aligned redirect (-> REQ, misalign_fault=0).
REQ-031 Macro undefined: redirect_pc[1:0] ignored (pc low bits forced 0), FAULT unreachable, misalign_fault tied 0.

Verification
REQ-032 Reset release, mem_req_ready=1, resp one cycle later with 32'h0010_0093, out_ready=1 -> out_inst=32'h0010_0093, out_pc=32'h8000_0000; next mem_req_addr=32'h8000_0004.
REQ-033 out_ready held 0 for 5 cycles in OUT -> out_valid, out_inst, out_pc stable, no new mem_req_valid.
REQ-034 Redirect to 32'h8000_0100 while in WAIT -> pending response dropped, next mem_req_addr=32'h8000_0100, first out_pc=32'h8000_0100.
REQ-035 Redirect coincident with out_ready handshake in OUT -> pc=redirect_pc, not pc+4.
REQ-036 With macro: redirect_pc=32'h8000_0102 -> misalign_fault=1, no requests; then redirect 32'h8000_0200 -> fault clears, mem_req_addr=32'h8000_0200. Without macro: same target -> mem_req_addr=32'h8000_0100.
REQ-037 rst_n pulsed low in WAIT -> all outputs at reset values immediately; late mem_resp_valid produces no out_valid.

Source files
------------

// File: rtl/ysyx_23060286_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, redirect with stale-response drop.
// Optional macro YSYX_23060286_IFU_MISALIGN_EN enables the misaligned-redirect FAULT state.
module ysyx_23060286_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_fault
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_FAULT
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic              drop;
    logic              req_fire;
    logic              redirect_bad;
    logic              kill_pending;
    logic [XLEN-1:0]   redirect_tgt;
    logic [XLEN-1:0]   pc_seq;

    assign req_fire     = mem_req_valid & mem_req_ready;
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_seq       = pc + XLEN'(4);

`ifdef YSYX_23060286_IFU_MISALIGN_EN
    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign redirect_bad = 1'b0;
    assign unused_lsb   = ^redirect_pc[1:0];
`endif

    // A request accepted by memory whose response has not been seen yet must be discarded
    assign kill_pending = ((state == S_REQ) && req_fire) ||
                          ((state == S_WAIT) && !mem_resp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            drop           <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= RESET_PC;
            out_valid      <= 1'b0;
            out_inst       <= '0;
            out_pc         <= '0;
            misalign_fault <= 1'b0;
        end else if (redirect_valid && (state != S_FAULT)) begin
            if (redirect_bad) begin
                state          <= S_FAULT;
                drop           <= 1'b0;
                mem_req_valid  <= 1'b0;
                out_valid      <= 1'b0;
                misalign_fault <= 1'b1;
            end else begin
                pc        <= redirect_tgt;
                out_valid <= 1'b0;
                if (kill_pending) begin
                    state         <= S_WAIT;
                    drop          <= 1'b1;
                    mem_req_valid <= 1'b0;
                end else begin
                    state         <= S_REQ;
                    drop          <= 1'b0;
                    mem_req_valid <= 1'b1;
                    mem_req_addr  <= redirect_tgt;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state         <= S_REQ;
                    mem_req_valid <= 1'b1;
                    mem_req_addr  <= pc;
                end
                S_REQ: begin
                    if (req_fire) begin
                        state         <= S_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (drop) begin
                            drop          <= 1'b0;
                            state         <= S_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= pc;
                        end else begin
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                            out_inst  <= mem_resp_data;
                            out_pc    <= pc;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state         <= S_REQ;
                        out_valid     <= 1'b0;
                        pc            <= pc_seq;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= pc_seq;
                    end
                end
                S_FAULT: begin
                    if (redirect_valid && !redirect_bad) begin
                        state          <= S_REQ;
                        pc             <= redirect_tgt;
                        misalign_fault <= 1'b0;
                        mem_req_valid  <= 1'b1;
                        mem_req_addr   <= redirect_tgt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060286_ifu.sv
// Bench for ysyx_23060286_ifu: directed literal scenarios, then randomized traffic
// against a phase-level reference model with a per-cycle compare process.
module tb_ysyx_23060286_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int P_IDLE  = 0;
    localparam int P_REQ   = 1;
    localparam int P_WAIT  = 2;
    localparam int P_OUT   = 3;
    localparam int P_FAULT = 4;
`ifdef YSYX_23060286_IFU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        misalign_fault;

    always #5 clk = ~clk;

    ysyx_23060286_ifu #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_fault(misalign_fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase the fetch is in, the fetch pc, and the held instruction
    typedef struct {
        int          ph;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] opc;
        bit          drop;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.ph = P_IDLE; r.pc = RST_PC; r.inst = '0; r.opc = '0; r.drop = 1'b0;
        return r;
    endfunction

    function automatic mstate_t model_next(mstate_t s, bit rv, logic [31:0] rpc, bit rdy,
                                           bit resp, logic [31:0] data, bit ordy);
        mstate_t     n;
        logic [31:0] tgt;
        bit          bad;
        n   = s;
        tgt = rpc & 32'hFFFF_FFFC;
        bad = MIS_EN && (rpc[1:0] != 2'b00);
        if (s.ph == P_FAULT) begin
            if (rv && !bad) begin n.ph = P_REQ; n.pc = tgt; end
        end else if (rv) begin
            if (bad) begin
                n.ph = P_FAULT; n.drop = 1'b0;
            end else begin
                n.pc = tgt;
                if ((s.ph == P_REQ && rdy) || (s.ph == P_WAIT && !resp)) begin
                    n.ph = P_WAIT; n.drop = 1'b1;
                end else begin
                    n.ph = P_REQ; n.drop = 1'b0;
                end
            end
        end else begin
            if (s.ph == P_IDLE) n.ph = P_REQ;
            else if (s.ph == P_REQ && rdy) n.ph = P_WAIT;
            else if (s.ph == P_WAIT && resp) begin
                if (s.drop) begin n.ph = P_REQ; n.drop = 1'b0; end
                else begin n.ph = P_OUT; n.inst = data; n.opc = s.pc; end
            end else if (s.ph == P_OUT && ordy) begin
                n.ph = P_REQ; n.pc = s.pc + 32'd4;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else m <= model_next(m, redirect_valid, redirect_pc, mem_req_ready,
                             mem_resp_valid, mem_resp_data, out_ready);
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                check("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
                check("rst out_valid", 32'(out_valid), 32'd0);
                check("rst misalign_fault", 32'(misalign_fault), 32'd0);
            end else begin
                check("mem_req_valid", 32'(mem_req_valid), 32'(m.ph == P_REQ));
                if (m.ph == P_REQ) check("mem_req_addr", mem_req_addr, m.pc);
                check("out_valid", 32'(out_valid), 32'(m.ph == P_OUT));
                if (m.ph == P_OUT) begin
                    check("out_inst", out_inst, m.inst);
                    check("out_pc", out_pc, m.opc);
                end
                check("misalign_fault", 32'(misalign_fault), 32'(m.ph == P_FAULT));
            end
        end
    end

    task automatic set_in(input bit rv, input logic [31:0] rpc, input bit rdy,
                          input bit resp, input logic [31:0] data, input bit ordy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_req_ready  = rdy;
        mem_resp_valid = resp;
        mem_resp_data  = data;
        out_ready      = ordy;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        check({tag, " mem_req_addr"}, mem_req_addr, 32'h8000_0000);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_inst"}, out_inst, 32'd0);
        check({tag, " out_pc"}, out_pc, 32'd0);
        check({tag, " misalign_fault"}, 32'(misalign_fault), 32'd0);
    endtask

    int          resp_cnt;
    bit          r_rv, r_rdy, r_resp, r_ordy;
    logic [31:0] r_rpc;

    initial begin
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // basic fetch and sequential pc
        @(negedge clk);
        check("d1 req_valid", 32'(mem_req_valid), 32'd1);
        check("d1 req_addr", mem_req_addr, 32'h8000_0000);
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h0010_0093, 1'b0);
        @(negedge clk);
        check("d1 out_valid", 32'(out_valid), 32'd1);
        check("d1 out_inst", out_inst, 32'h0010_0093);
        check("d1 out_pc", out_pc, 32'h8000_0000);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("d1 next_addr", mem_req_addr, 32'h8000_0004);
        check("d1 next_valid", 32'(mem_req_valid), 32'd1);

        // decode back-pressure holds the instruction
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h0020_0113, 1'b0);
        @(negedge clk);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("d2 hold out_valid", 32'(out_valid), 32'd1);
            check("d2 hold out_inst", out_inst, 32'h0020_0113);
            check("d2 hold out_pc", out_pc, 32'h8000_0004);
            check("d2 hold no_req", 32'(mem_req_valid), 32'd0);
        end
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("d2 next_addr", mem_req_addr, 32'h8000_0008);

        // redirect while waiting drops the in-flight response
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        set_in(1'b1, 32'h8000_0100, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("d3 dropped out_valid", 32'(out_valid), 32'd0);
        check("d3 req_addr", mem_req_addr, 32'h8000_0100);
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h0030_0193, 1'b0);
        @(negedge clk);
        check("d3 out_pc", out_pc, 32'h8000_0100);
        check("d3 out_inst", out_inst, 32'h0030_0193);

        // redirect beats a same-cycle decode handshake
        set_in(1'b1, 32'h8000_0040, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("d4 req_addr", mem_req_addr, 32'h8000_0040);
        check("d4 out_valid", 32'(out_valid), 32'd0);

        // misaligned redirect target
        set_in(1'b1, 32'h8000_0102, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        if (MIS_EN) begin
            check("d5 fault", 32'(misalign_fault), 32'd1);
            check("d5 fault no_req", 32'(mem_req_valid), 32'd0);
            set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
            repeat (2) @(negedge clk);
            check("d5 fault held", 32'(misalign_fault), 32'd1);
            check("d5 fault still no_req", 32'(mem_req_valid), 32'd0);
            set_in(1'b1, 32'h8000_0200, 1'b0, 1'b0, '0, 1'b0);
            @(negedge clk);
            check("d5 fault cleared", 32'(misalign_fault), 32'd0);
            check("d5 req_addr", mem_req_addr, 32'h8000_0200);
        end else begin
            check("d5 no fault", 32'(misalign_fault), 32'd0);
            check("d5 req_addr", mem_req_addr, 32'h8000_0100);
        end

        // asynchronous reset while waiting; late response must be ignored
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("d6 async");
        set_in(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("d6 late resp out_valid", 32'(out_valid), 32'd0);
        check("d6 req_addr", mem_req_addr, 32'h8000_0000);
        @(negedge clk);
        check("d6 late resp2 out_valid", 32'(out_valid), 32'd0);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);

        // randomized traffic; memory answers 1..3 cycles after acceptance
        resp_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            r_resp = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) r_resp = 1'b1;
            end else if (m.ph != P_WAIT && $urandom_range(0, 9) == 0) begin
                r_resp = 1'b1;
            end
            r_rdy = (resp_cnt == 0) && ($urandom_range(0, 1) == 1);
            if (m.ph == P_REQ && r_rdy) resp_cnt = int'($urandom_range(1, 3));
            r_rv  = ($urandom_range(0, 7) == 0);
            r_rpc = {16'h8000, 16'($urandom)};
            if ($urandom_range(0, 3) != 0) r_rpc[1:0] = 2'b00;
            if ($urandom_range(0, 49) == 0) r_rpc = 32'hFFFF_FFFC;
            r_ordy = ($urandom_range(0, 9) < 6);
            set_in(r_rv, r_rpc, r_rdy, r_resp, $urandom, r_ordy);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
